// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the shared MSP430 memory bus; drives MAB/MDBwrite/MW/BW from registers.
// Define MEM_ARB_WAIT_EN to insert WAIT_STATES extra bus cycles on FRAM accesses.
module mem_bus_arbiter #(
    parameter logic [15:0] FRAM_START    = 16'h4400,
    parameter logic [15:0] FRAM_END      = 16'hFFFF,
    parameter int unsigned WAIT_STATES   = 1,
    parameter int unsigned DMA_MAX_BURST = 4
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_mab,
    input  logic [15:0] cpu_mdbw,
    input  logic        cpu_mw,
    input  logic        cpu_bw,
    output logic        cpu_ack,
    output logic [15:0] cpu_mdbr,
    input  logic        dma_req,
    input  logic [15:0] dma_mab,
    input  logic [15:0] dma_mdbw,
    input  logic        dma_mw,
    input  logic        dma_bw,
    output logic        dma_ack,
    output logic [15:0] dma_mdbr,
    output logic [15:0] MAB,
    output logic [15:0] MDBwrite,
    output logic        MW,
    output logic        BW,
    input  logic [15:0] MDBread,
    output logic        busy
);
    // state  | meaning
    // IDLE   | arbitrate each edge; an ack strobe, if any, is high here
    // ACCESS | bus held for the granted master; wait states counted down
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
    localparam logic [7:0] BURST_MAX = 8'(DMA_MAX_BURST);
`ifdef MEM_ARB_WAIT_EN
    localparam logic [2:0] WAIT_MASK = 3'b111;
`else
    localparam logic [2:0] WAIT_MASK = 3'b000;
`endif

    state_t      state_q;
    logic [2:0]  wait_q;
    logic [7:0]  burst_q;
    logic        own_dma_q;
    logic        wr_q;
    logic [15:0] mab_q;
    logic [15:0] mdbw_q;
    logic        mw_q;
    logic        bw_q;
    logic        cpu_ack_q;
    logic        dma_ack_q;
    logic [15:0] cpu_mdbr_q;
    logic [15:0] dma_mdbr_q;

    logic        grant_dma;
    logic        grant_cpu;
    logic [15:0] sel_mab;
    logic [15:0] sel_mdbw;
    logic        sel_mw;
    logic        sel_bw;
    logic        in_fram;
    logic [2:0]  wait_d;

    always_comb begin
        grant_dma = dma_req && (!cpu_req || (burst_q < BURST_MAX));
        grant_cpu = cpu_req && !grant_dma;
        sel_mab   = grant_dma ? dma_mab  : cpu_mab;
        sel_mdbw  = grant_dma ? dma_mdbw : cpu_mdbw;
        sel_mw    = grant_dma ? dma_mw   : cpu_mw;
        sel_bw    = grant_dma ? dma_bw   : cpu_bw;
        // widened so a window ending at 16'hFFFF is not a constant-true compare
        in_fram   = ({1'b0, sel_mab} >= {1'b0, FRAM_START}) &&
                    ({1'b0, sel_mab} <= {1'b0, FRAM_END});
        wait_d    = in_fram ? (WAIT_LOAD & WAIT_MASK) : 3'd0;
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= 3'd0;
            burst_q    <= 8'd0;
            own_dma_q  <= 1'b0;
            wr_q       <= 1'b0;
            mab_q      <= 16'd0;
            mdbw_q     <= 16'd0;
            mw_q       <= 1'b0;
            bw_q       <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            cpu_mdbr_q <= 16'd0;
            dma_mdbr_q <= 16'd0;
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dma || grant_cpu) begin
                        mab_q     <= sel_mab;
                        mdbw_q    <= sel_mdbw;
                        bw_q      <= sel_bw;
                        wr_q      <= sel_mw;
                        own_dma_q <= grant_dma;
                        wait_q    <= wait_d;
                        mw_q      <= sel_mw && (wait_d == 3'd0);
                        state_q   <= ACCESS;
                    end
                    if (grant_dma && cpu_req) begin
                        if (burst_q != 8'hFF) begin
                            burst_q <= burst_q + 8'd1;
                        end
                    end else if (grant_cpu || !cpu_req) begin
                        burst_q <= 8'd0;
                    end
                end
                ACCESS: begin
                    if (wait_q != 3'd0) begin
                        wait_q <= wait_q - 3'd1;
                        mw_q   <= wr_q && (wait_q == 3'd1);
                    end else begin
                        if (own_dma_q) begin
                            dma_ack_q <= 1'b1;
                            if (!wr_q) begin
                                dma_mdbr_q <= MDBread;
                            end
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!wr_q) begin
                                cpu_mdbr_q <= MDBread;
                            end
                        end
                        mw_q    <= 1'b0;
                        mab_q   <= 16'd0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack  = cpu_ack_q;
    assign cpu_mdbr = cpu_mdbr_q;
    assign dma_ack  = dma_ack_q;
    assign dma_mdbr = dma_mdbr_q;
    assign MAB      = mab_q;
    assign MDBwrite = mdbw_q;
    assign MW       = mw_q;
    assign BW       = bw_q;
    assign busy     = (state_q == ACCESS);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model, bus memory, directed and random traffic.
// Follows MEM_ARB_WAIT_EN the same way the design does.
module tb_mem_bus_arbiter;
    localparam int WS_PARAM  = 2;
    localparam int MAX_BURST = 4;
`ifdef MEM_ARB_WAIT_EN
    localparam int WS_EFF = WS_PARAM;
`else
    localparam int WS_EFF = 0;
`endif

    logic        MCLK;
    logic        reset;
    logic        cpu_req, cpu_mw, cpu_bw;
    logic [15:0] cpu_mab, cpu_mdbw;
    logic        dma_req, dma_mw, dma_bw;
    logic [15:0] dma_mab, dma_mdbw;
    logic        cpu_ack, dma_ack, MW, BW, busy;
    logic [15:0] cpu_mdbr, dma_mdbr, MAB, MDBwrite, MDBread;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .FRAM_START(16'h4400), .FRAM_END(16'hFFFF),
        .WAIT_STATES(WS_PARAM), .DMA_MAX_BURST(MAX_BURST)
    ) dut (
        .MCLK(MCLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_mab(cpu_mab), .cpu_mdbw(cpu_mdbw), .cpu_mw(cpu_mw), .cpu_bw(cpu_bw),
        .cpu_ack(cpu_ack), .cpu_mdbr(cpu_mdbr),
        .dma_req(dma_req), .dma_mab(dma_mab), .dma_mdbw(dma_mdbw), .dma_mw(dma_mw), .dma_bw(dma_bw),
        .dma_ack(dma_ack), .dma_mdbr(dma_mdbr),
        .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW), .MDBread(MDBread), .busy(busy)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // bus memory seen by the DUT: combinational read, write on posedge when MW
    logic [15:0] bus_mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    assign MDBread = bus_mem[MAB[15:1]];

    always @(posedge MCLK) begin
        if (MW) begin
            if (BW) begin
                if (MAB[0]) bus_mem[MAB[15:1]][15:8] = MDBwrite[7:0];
                else        bus_mem[MAB[15:1]][7:0]  = MDBwrite[7:0];
            end else begin
                bus_mem[MAB[15:1]] = MDBwrite;
            end
        end
    end

    task automatic ref_write(input logic [15:0] a, input logic [15:0] d, input logic b);
        if (b) begin
            if (a[0]) ref_mem[a[15:1]][15:8] = d[7:0];
            else      ref_mem[a[15:1]][7:0]  = d[7:0];
        end else begin
            ref_mem[a[15:1]] = d;
        end
    endtask

    function automatic int fram_waits(input logic [15:0] a);
        return (int'(a) >= 'h4400 && int'(a) <= 'hFFFF) ? WS_EFF : 0;
    endfunction

    // reference model: an access granted at edge n completes at edge n+1+waits;
    // MW is expected only in the cycle just before that completing edge
    int          n_edge = 0;
    bit          m_valid = 0;
    bit          m_act = 0, m_own_dma = 0, m_wr = 0;
    int          m_end = 0;
    int          burst = 0;
    logic [15:0] e_mab = 0, e_mdbw = 0, e_cmdbr = 0, e_dmdbr = 0;
    logic        e_mw = 0, e_bw = 0, e_cack = 0, e_dack = 0, e_busy = 0;

    always @(posedge MCLK) begin
        bit g_dma, g_cpu;
        n_edge++;
        if (e_mw) ref_write(e_mab, e_mdbw, e_bw);
        if (reset) begin
            m_valid = 1; m_act = 0; burst = 0;
            e_mab = 0; e_mdbw = 0; e_cmdbr = 0; e_dmdbr = 0;
            e_mw = 0; e_bw = 0; e_cack = 0; e_dack = 0; e_busy = 0;
        end else begin
            e_cack = 0; e_dack = 0;
            if (m_act) begin
                if (n_edge == m_end) begin
                    if (m_own_dma) begin
                        e_dack = 1;
                        if (!m_wr) e_dmdbr = ref_mem[e_mab[15:1]];
                    end else begin
                        e_cack = 1;
                        if (!m_wr) e_cmdbr = ref_mem[e_mab[15:1]];
                    end
                    m_act = 0; e_mab = 0; e_mw = 0;
                end else begin
                    e_mw = m_wr && (n_edge + 1 == m_end);
                end
            end else begin
                g_dma = dma_req && (!cpu_req || burst < MAX_BURST);
                g_cpu = !g_dma && cpu_req;
                if (g_dma || g_cpu) begin
                    m_act     = 1;
                    m_own_dma = g_dma;
                    e_mab     = g_dma ? dma_mab  : cpu_mab;
                    e_mdbw    = g_dma ? dma_mdbw : cpu_mdbw;
                    e_bw      = g_dma ? dma_bw   : cpu_bw;
                    m_wr      = g_dma ? dma_mw   : cpu_mw;
                    m_end     = n_edge + 1 + fram_waits(e_mab);
                    e_mw      = m_wr && (n_edge + 1 == m_end);
                end
                if (g_dma && cpu_req) burst = burst + 1;
                else if (g_cpu || !cpu_req) burst = 0;
            end
            e_busy = m_act;
        end
    end

    always @(negedge MCLK) begin
        if (m_valid) begin
            chk("MAB", MAB, e_mab);
            chk("MDBwrite", MDBwrite, e_mdbw);
            chk("MW", MW, e_mw);
            chk("BW", BW, e_bw);
            chk("busy", busy, e_busy);
            chk("cpu_ack", cpu_ack, e_cack);
            chk("dma_ack", dma_ack, e_dack);
            chk("cpu_mdbr", cpu_mdbr, e_cmdbr);
            chk("dma_mdbr", dma_mdbr, e_dmdbr);
            chk("ack_exclusive", cpu_ack & dma_ack, 0);
        end
    end

    task automatic drive(input bit is_dma, input bit req, input logic [15:0] a,
                         input logic [15:0] d, input bit w, input bit b);
        if (is_dma) begin
            dma_req = req; dma_mab = a; dma_mdbw = d; dma_mw = w; dma_bw = b;
        end else begin
            cpu_req = req; cpu_mab = a; cpu_mdbw = d; cpu_mw = w; cpu_bw = b;
        end
    endtask

    task automatic do_access(input bit is_dma, input logic [15:0] a, input logic [15:0] d,
                             input bit w, input bit b, output int lat, output logic [15:0] rdata,
                             output int mw_mask, output logic [15:0] mab1, output logic [15:0] mdbw1,
                             output logic bw1);
        lat = 0; rdata = 0; mw_mask = 0; mab1 = 0; mdbw1 = 0; bw1 = 0;
        @(negedge MCLK);
        drive(is_dma, 1'b1, a, d, w, b);
        for (int k = 1; k <= 30; k++) begin
            @(negedge MCLK);
            if (MW) mw_mask |= (1 << k);
            if (k == 1) begin mab1 = MAB; mdbw1 = MDBwrite; bw1 = BW; end
            if (is_dma ? dma_ack : cpu_ack) begin
                lat = k;
                rdata = is_dma ? dma_mdbr : cpu_mdbr;
                drive(is_dma, 1'b0, a, d, w, b);
                break;
            end
        end
        chk("ack_within_budget", lat != 0, 1);
        if (lat == 0) drive(is_dma, 1'b0, a, d, w, b);
    endtask

    function automatic logic [15:0] rnd_addr();
        int r = int'($urandom_range(0, 3));
        logic [15:0] base;
        case (r)
            0: base = 16'h2000;
            1: base = 16'h43F0;
            2: base = 16'h4400;
            default: base = 16'hFFE0;
        endcase
        return base + 16'($urandom_range(0, 31));
    endfunction

    task automatic rnd_master(input bit is_dma);
        bit ack = is_dma ? dma_ack : cpu_ack;
        bit req = is_dma ? dma_req : cpu_req;
        if (ack) begin
            if ($urandom_range(0, 1) == 1)
                drive(is_dma, 1'b1, rnd_addr(), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (is_dma) dma_req = 1'b0;
            else cpu_req = 1'b0;
        end else if (!req) begin
            if ($urandom_range(0, is_dma ? 1 : 3) == 0)
                drive(is_dma, 1'b1, rnd_addr(), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 7) == 0) begin
            // operand churn on a held request; ignored once granted
            drive(is_dma, 1'b1, rnd_addr(), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, mw_mask, nacks, nwait;
        logic [15:0] rd, mab1, mdbw1;
        logic bw1, overlap, mw_seen, ack_seen;
        logic [9:0] seq;

        for (int i = 0; i < 32768; i++) begin
            bus_mem[i] = 16'(i * 7 + 3) ^ 16'hA5C3;
            ref_mem[i] = 16'(i * 7 + 3) ^ 16'hA5C3;
        end
        bus_mem[16'h1000] = 16'hBEEF;
        ref_mem[16'h1000] = 16'hBEEF;

        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge MCLK);
        chk("reset_MAB", MAB, 0);
        chk("reset_MW", MW, 0);
        chk("reset_busy", busy, 0);
        chk("reset_acks", {cpu_ack, dma_ack}, 0);
        chk("reset_mdbr", {cpu_mdbr, dma_mdbr}, 0);
        reset = 1'b0;

        // RAM read
        do_access(1'b0, 16'h2000, 16'h0, 1'b0, 1'b0, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("ram_read_latency", lat, 2);
        chk("ram_read_data", rd, 16'hBEEF);
        chk("ram_read_MAB", mab1, 16'h2000);
        chk("ram_read_no_MW", mw_mask, 0);

        // FRAM word write then readback
        do_access(1'b0, 16'h4400, 16'h1234, 1'b1, 1'b0, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("fram_write_latency", lat, 2 + WS_EFF);
        chk("fram_write_MW_cycle", mw_mask, 1 << (1 + WS_EFF));
        chk("fram_write_MDBwrite", mdbw1, 16'h1234);
        do_access(1'b0, 16'h4400, 16'h0, 1'b0, 1'b0, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("fram_readback_latency", lat, 2 + WS_EFF);
        chk("fram_readback_data", rd, 16'h1234);

        // DMA byte write to the odd byte; the even byte keeps 8'hEF
        do_access(1'b1, 16'h2001, 16'h3CA5, 1'b1, 1'b1, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("byte_write_BW", bw1, 1);
        chk("byte_write_data", mdbw1[7:0], 8'hA5);
        chk("byte_write_MW_cycle", mw_mask, 2);
        do_access(1'b1, 16'h2000, 16'h0, 1'b0, 1'b0, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("byte_readback", rd, 16'hA5EF);

        // top of the FRAM window
        do_access(1'b0, 16'hFFFE, 16'h0, 1'b0, 1'b0, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("fram_top_latency", lat, 2 + WS_EFF);

        // both masters held: DMA gets MAX_BURST grants, then CPU
        @(negedge MCLK);
        drive(1'b0, 1'b1, 16'h2010, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h2020, 16'h0, 1'b0, 1'b0);
        seq = '0; nacks = 0; overlap = 1'b0;
        for (int k = 0; k < 200 && nacks < 10; k++) begin
            @(negedge MCLK);
            if (cpu_ack && dma_ack) overlap = 1'b1;
            if (cpu_ack || dma_ack) begin
                seq = {seq[8:0], dma_ack};
                nacks++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("grant_order", seq, 10'b1111011110);
        chk("grant_count", nacks, 10);
        chk("ack_overlap", overlap, 0);

        // reset in the middle of an FRAM access
        @(negedge MCLK);
        drive(1'b0, 1'b1, 16'h4400, 16'h7777, (WS_EFF >= 2), 1'b0);
        nwait = (WS_EFF >= 2) ? 2 : 1;
        mw_seen = 1'b0; ack_seen = 1'b0;
        for (int k = 0; k < nwait; k++) begin
            @(negedge MCLK);
            mw_seen |= MW;
            ack_seen |= cpu_ack | dma_ack;
        end
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge MCLK);
        chk("abort_MW", MW, 0);
        chk("abort_MAB", MAB, 0);
        chk("abort_MDBwrite", MDBwrite, 0);
        chk("abort_busy", busy, 0);
        chk("abort_acks", {cpu_ack, dma_ack}, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge MCLK);
            mw_seen |= MW;
            ack_seen |= cpu_ack | dma_ack;
        end
        chk("abort_no_MW_pulse", mw_seen, 0);
        chk("abort_no_ack", ack_seen, 0);
        do_access(1'b0, 16'h4400, 16'h0, 1'b0, 1'b0, lat, rd, mw_mask, mab1, mdbw1, bw1);
        chk("after_abort_latency", lat, 2 + WS_EFF);
        chk("after_abort_data", rd, 16'h1234);

        // random two-master traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge MCLK);
            rnd_master(1'b0);
            rnd_master(1'b1);
        end
        @(negedge MCLK);
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (12) @(negedge MCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
